// File: rtl/instruction_assembler.sv
// instruction_assembler: builds a 32-bit instruction {0, funct, immA, immB}
// from a keypad stream. Keys select an operation, then two decimal operands
// are typed and terminated by ENTER. The finished word is held until the
// downstream decoder takes it.
//
// Handshakes: both sides use valid/ready. A key is consumed only on an edge
// where key_valid & key_ready; the instruction is transferred only on an edge
// where instr_valid & instr_ready. Valid never depends on ready, and instr is
// held stable while instr_valid is high and not yet accepted.
module instruction_assembler #(
   parameter int DIGIT_LIMIT = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_valid,
   input  logic [4:0]  key_code,
   output logic        key_ready,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [1:0]  field,
   output logic [13:0] display_val,
   output logic        key_err
);

   localparam int CNT_W = $clog2(DIGIT_LIMIT + 1);
   localparam logic [17:0] ACC_MAX = 18'd16383;

   typedef enum logic [1:0] {
      S_FUNCT = 2'd0,
      S_A     = 2'd1,
      S_B     = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         funct_q, funct_d;
   logic [13:0]        imma_q, imma_d;
   logic [13:0]        immb_q, immb_d;
   logic [13:0]        acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;

   // Key classification and candidate accumulator value. The product is
   // formed in 18 bits so overflow past 14 bits is still visible to the
   // range check.
   logic        accept;
   logic        is_digit, is_enter, is_clear, is_op;
   logic [17:0] acc_next;
   logic        digit_ok;

   assign accept   = key_valid & key_ready;
   assign is_digit = (key_code <= 5'd9);
   assign is_enter = (key_code == 5'd10);
   assign is_clear = (key_code == 5'd11);
   assign is_op    = (key_code[4:3] == 2'b10);
   assign acc_next = ({4'b0, acc_q} * 18'd10) + {14'b0, key_code[3:0]};
   assign digit_ok = (cnt_q < CNT_W'(DIGIT_LIMIT)) && (acc_next <= ACC_MAX);

   // State and datapath registers; reset wins over keys and handshakes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FUNCT;
         funct_q <= '0;
         imma_q  <= '0;
         immb_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         funct_q <= funct_d;
         imma_q  <= imma_d;
         immb_q  <= immb_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Next-state and datapath update for every accepted key or transfer.
   always_comb begin
      state_d = state_q;
      funct_d = funct_q;
      imma_d  = imma_q;
      immb_d  = immb_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;

      if (state_q == S_HOLD) begin
         // Keys are not consumed here; only the downstream transfer leaves.
         if (instr_ready) begin
            state_d = S_FUNCT;
            funct_d = '0;
            imma_d  = '0;
            immb_d  = '0;
            acc_d   = '0;
            cnt_d   = '0;
         end
      end else if (accept) begin
         if (is_clear) begin
            state_d = S_FUNCT;
            funct_d = '0;
            imma_d  = '0;
            immb_d  = '0;
            acc_d   = '0;
            cnt_d   = '0;
         end else begin
            case (state_q)
               S_FUNCT: begin
                  if (is_op) begin
                     funct_d = key_code[2:0];
                     acc_d   = '0;
                     cnt_d   = '0;
                     state_d = S_A;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               S_A, S_B: begin
                  if (is_digit) begin
                     if (digit_ok) begin
                        acc_d = acc_next[13:0];
                        cnt_d = cnt_q + 1'b1;
                     end else begin
                        err_d = 1'b1;
                     end
                  end else if (is_enter) begin
                     if (state_q == S_A) begin
                        imma_d  = acc_q;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_B;
                     end else begin
                        immb_d  = acc_q;
                        state_d = S_HOLD;
                     end
                  end else if (is_op && (state_q == S_A)) begin
                     funct_d = key_code[2:0];
                  end else begin
                     err_d = 1'b1;
                  end
               end
               default: begin
                  err_d = 1'b0;
               end
            endcase
         end
      end
   end

   assign key_ready   = (state_q != S_HOLD);
   assign instr_valid = (state_q == S_HOLD);
   assign instr       = {1'b0, funct_q, imma_q, immb_q};
   assign field       = state_q;
   assign display_val = acc_q;
   assign key_err     = err_q;

endmodule

// File: tb/tb_instruction_assembler.sv
// Bench for instruction_assembler: a table of single-key vectors walked from
// reset, then hand-written sequences for hold/stall, transfer, clear and
// reset-in-hold. Inputs change and outputs are sampled on the falling edge.
module tb_instruction_assembler;

   logic        clk;
   logic        rst_n;
   logic        key_valid;
   logic [4:0]  key_code;
   logic        key_ready;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [1:0]  field;
   logic [13:0] display_val;
   logic        key_err;

   int total;
   int bad;

   instruction_assembler #(.DIGIT_LIMIT(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_ready   (key_ready),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .field       (field),
      .display_val (display_val),
      .key_err     (key_err)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  code;
      logic [1:0]  fld;
      logic [13:0] disp;
      logic        err;
      logic        vld;
      logic [31:0] ins;
   } vec_t;

   vec_t vecs[21];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Present one key for one edge; returns on the falling edge after it.
   task automatic press(input logic [4:0] code);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = code;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 5'd0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " field"}, 32'(field), 32'd0);
      check({tag, " disp"}, 32'(display_val), 32'd0);
      check({tag, " instr"}, instr, 32'd0);
      check({tag, " valid"}, 32'(instr_valid), 32'd0);
      check({tag, " ready"}, 32'(key_ready), 32'd1);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n       = 1'b0;
      key_valid   = 1'b0;
      key_code    = 5'd0;
      instr_ready = 1'b0;

      //                code    fld   disp        err   vld   instr
      vecs[0]  = '{5'd7,  2'd0, 14'd0,     1'b1, 1'b0, 32'h0000_0000};
      vecs[1]  = '{5'd10, 2'd0, 14'd0,     1'b1, 1'b0, 32'h0000_0000};
      vecs[2]  = '{5'd12, 2'd0, 14'd0,     1'b1, 1'b0, 32'h0000_0000};
      vecs[3]  = '{5'd19, 2'd1, 14'd0,     1'b0, 1'b0, 32'h3000_0000};
      vecs[4]  = '{5'd1,  2'd1, 14'd1,     1'b0, 1'b0, 32'h3000_0000};
      vecs[5]  = '{5'd6,  2'd1, 14'd16,    1'b0, 1'b0, 32'h3000_0000};
      vecs[6]  = '{5'd3,  2'd1, 14'd163,   1'b0, 1'b0, 32'h3000_0000};
      vecs[7]  = '{5'd8,  2'd1, 14'd1638,  1'b0, 1'b0, 32'h3000_0000};
      vecs[8]  = '{5'd3,  2'd1, 14'd16383, 1'b0, 1'b0, 32'h3000_0000};
      vecs[9]  = '{5'd0,  2'd1, 14'd16383, 1'b1, 1'b0, 32'h3000_0000};
      vecs[10] = '{5'd25, 2'd1, 14'd16383, 1'b1, 1'b0, 32'h3000_0000};
      vecs[11] = '{5'd17, 2'd1, 14'd16383, 1'b0, 1'b0, 32'h1000_0000};
      vecs[12] = '{5'd10, 2'd2, 14'd0,     1'b0, 1'b0, 32'h1FFF_C000};
      vecs[13] = '{5'd16, 2'd2, 14'd0,     1'b1, 1'b0, 32'h1FFF_C000};
      vecs[14] = '{5'd0,  2'd2, 14'd0,     1'b0, 1'b0, 32'h1FFF_C000};
      vecs[15] = '{5'd0,  2'd2, 14'd0,     1'b0, 1'b0, 32'h1FFF_C000};
      vecs[16] = '{5'd0,  2'd2, 14'd0,     1'b0, 1'b0, 32'h1FFF_C000};
      vecs[17] = '{5'd0,  2'd2, 14'd0,     1'b0, 1'b0, 32'h1FFF_C000};
      vecs[18] = '{5'd1,  2'd2, 14'd1,     1'b0, 1'b0, 32'h1FFF_C000};
      vecs[19] = '{5'd2,  2'd2, 14'd1,     1'b1, 1'b0, 32'h1FFF_C000};
      vecs[20] = '{5'd10, 2'd3, 14'd1,     1'b0, 1'b1, 32'h1FFF_C001};

      // Reset
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_idle("reset");
      check("reset err", 32'(key_err), 32'd0);

      // Table walk from reset
      for (int i = 0; i < 21; i++) begin
         press(vecs[i].code);
         check($sformatf("vec%0d field", i), 32'(field), 32'(vecs[i].fld));
         check($sformatf("vec%0d disp", i), 32'(display_val), 32'(vecs[i].disp));
         check($sformatf("vec%0d err", i), 32'(key_err), 32'(vecs[i].err));
         check($sformatf("vec%0d valid", i), 32'(instr_valid), 32'(vecs[i].vld));
         check($sformatf("vec%0d instr", i), instr, vecs[i].ins);
         check($sformatf("vec%0d kready", i), 32'(key_ready), 32'(vecs[i].fld != 2'd3));
      end
      @(negedge clk);
      check("err drops", 32'(key_err), 32'd0);

      // Stall in hold with a key pending: nothing consumed, instr stable
      key_valid = 1'b1;
      key_code  = 5'd11;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("stall%0d kready", c), 32'(key_ready), 32'd0);
         check($sformatf("stall%0d instr", c), instr, 32'h1FFF_C001);
         check($sformatf("stall%0d err", c), 32'(key_err), 32'd0);
         check($sformatf("stall%0d valid", c), 32'(instr_valid), 32'd1);
      end
      key_valid   = 1'b0;
      key_code    = 5'd0;
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      check_idle("after stall");

      // Full instruction with ready already high: valid for exactly one cycle
      instr_ready = 1'b1;
      press(5'd19);
      press(5'd1);
      press(5'd2);
      press(5'd10);
      press(5'd4);
      press(5'd5);
      press(5'd10);
      check("xfer valid", 32'(instr_valid), 32'd1);
      check("xfer instr", instr, 32'h3003_002D);
      check("xfer field", 32'(field), 32'd3);
      @(negedge clk);
      instr_ready = 1'b0;
      check_idle("after xfer");

      // Digit that pushes past 16383 is rejected, then CLEAR
      press(5'd16);
      press(5'd1);
      press(5'd6);
      press(5'd3);
      press(5'd8);
      press(5'd4);
      check("ovf err", 32'(key_err), 32'd1);
      check("ovf disp", 32'(display_val), 32'd1638);
      press(5'd11);
      check_idle("clear A");
      check("clear A err", 32'(key_err), 32'd0);

      // CLEAR from S_B discards everything and never raises valid
      press(5'd16);
      check("seq46 v0", 32'(instr_valid), 32'd0);
      press(5'd5);
      check("seq46 v1", 32'(instr_valid), 32'd0);
      press(5'd10);
      check("seq46 field B", 32'(field), 32'd2);
      press(5'd3);
      check("seq46 v2", 32'(instr_valid), 32'd0);
      press(5'd11);
      check_idle("clear B");

      // Zero-digit ENTER latches 0; then reset in hold beats key and ready
      press(5'd18);
      press(5'd10);
      press(5'd9);
      press(5'd10);
      check("hold2 valid", 32'(instr_valid), 32'd1);
      check("hold2 instr", instr, 32'h2000_0009);
      rst_n       = 1'b0;
      key_valid   = 1'b1;
      key_code    = 5'd19;
      instr_ready = 1'b1;
      @(negedge clk);
      rst_n       = 1'b1;
      key_valid   = 1'b0;
      key_code    = 5'd0;
      instr_ready = 1'b0;
      check_idle("rst hold");
      check("rst hold err", 32'(key_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_assembler.md
INSTRUCTION_ASSEMBLER -- requirements
Module: instruction_assembler

Interface
REQ-001 Parameter: DIGIT_LIMIT, 5, maximum decimal digits accepted per operand field.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 key_valid  input  1  a key event is presented on key_code.
REQ-006 key_code  input  5  key: 0-9 digit, 10 ENTER, 11 CLEAR, 16-23 operation select 0-7; all other codes invalid.
REQ-007 key_ready  output  1  block can accept a key; a key is consumed only on key_valid & key_ready.
REQ-008 instr  output  32  assembled instruction {1'b0, funct[2:0], immA[13:0], immB[13:0]}.
REQ-009 instr_valid  output  1  instr is complete and held stable.
REQ-010 instr_ready  input  1  downstream decoder accepts instr; transfer on instr_valid & instr_ready.
REQ-011 field  output  2  current state encoding, for display.
REQ-012 display_val  output  14  current operand accumulator value.
REQ-013 key_err  output  1  one-cycle pulse: the previous accepted key was rejected.

Function
REQ-014 States SHALL be S_FUNCT=0, S_A=1, S_B=2, S_HOLD=3, driven on field.
REQ-015 key_ready SHALL be 1 in S_FUNCT, S_A, and S_B, and 0 in S_HOLD.
REQ-016 instr SHALL be combinational from the registered funct, immA, and immB; instr_valid SHALL be 1 exactly in S_HOLD.
REQ-017 In S_FUNCT, an operation key SHALL set funct=key_code-16, clear acc and the digit count, and move to S_A.
REQ-018 In S_FUNCT, a digit or ENTER SHALL be rejected, with the state unchanged.
REQ-019 In S_A or S_B, an accepted digit d SHALL set acc=acc*10+d only if digit count<DIGIT_LIMIT and acc*10+d<=16383.
REQ-020 The acc*10+d product SHALL be computed in at least 18 bits before the 16383 comparison.
REQ-021 In S_A or S_B, a digit that fails either check in REQ-019 SHALL be rejected, leaving acc and the digit count unchanged.
REQ-022 In S_A, ENTER SHALL latch immA=acc, clear acc and the digit count, and move to S_B.
REQ-023 In S_A, an operation key SHALL overwrite funct and stay in S_A.
REQ-024 In S_B, ENTER SHALL latch immB=acc and move to S_HOLD, with instr_valid visible in the cycle after the ENTER edge.
REQ-025 In S_B, an operation key SHALL be rejected.
REQ-026 ENTER with zero digits entered SHALL latch a field value of 0.
REQ-027 CLEAR in any state other than S_HOLD SHALL zero funct, immA, immB, acc, and the digit count, and move to S_FUNCT.
REQ-028 In S_HOLD, instr SHALL stay stable and keys SHALL not be consumed.
REQ-029 On instr_valid & instr_ready, the next state SHALL be S_FUNCT with all fields and acc zeroed.
REQ-030 instr_ready may be high on the first S_HOLD cycle; instr_valid then lasts exactly 1 cycle.
REQ-031 An invalid key_code accepted in any non-HOLD state SHALL be rejected, with the state unchanged.
REQ-032 A rejected key SHALL assert key_err for exactly one cycle following the accepting edge.
REQ-033 key_err SHALL be 0 at all other times.
REQ-034 display_val SHALL equal acc at all times.

Reset
REQ-035 While rst_n=0 at a rising edge, the block SHALL enter S_FUNCT.
REQ-036 That reset SHALL zero funct, immA, immB, acc, and the digit count.
REQ-037 After reset, instr=0, instr_valid=0, key_err=0, field=0, display_val=0, and key_ready=1.
REQ-038 Reset SHALL take priority over any key or handshake in the same cycle.
REQ-039 Reset in S_HOLD SHALL drop instr_valid in the next cycle without a transfer.

Verification
REQ-040 Keys 19,1,2,10,4,5,10 with instr_ready=1 -> instr=0x3003_002D, instr_valid high for exactly 1 cycle, then field=0.
REQ-041 In S_A, keys 1,6,3,8,3 -> display_val=16383; a further key 0 -> key_err pulse, display_val stays 16383.
REQ-042 In S_A, keys 1,6,3,8,4 -> last digit rejected, key_err pulse, display_val=1638.
REQ-043 In S_HOLD, hold instr_ready=0 for 10 cycles while key_valid=1 -> key_ready=0, instr unchanged, no key_err.
REQ-044 Raise instr_ready after the REQ-043 stall -> one transfer, then field=0.
REQ-045 Digit key 7 in S_FUNCT -> key_err=1 for one cycle, field stays 0.
REQ-046 Keys 16,5,10,3,11 -> field=0, display_val=0, instr=0, instr_valid never set.
REQ-047 rst_n=0 for one edge while in S_HOLD with instr_ready=0 -> next cycle instr_valid=0, instr=0, key_ready=1.
